abro_stim_driver: RTL and testbench
===================================

// Module: abro_stim_driver
// PURPOSE
//  Synthesizable stimulus driver and response checker for the ABRO state machine.
//  Drives the DUT's reset, A and B inputs with trial sequences and samples its O output.
//  Scores each trial pass/fail: O must rise after both A and B were seen, never before.
//  Sits on the input side of the ABRO block, so self-checking runs in sim or on FPGA.
// PARAMETERS
//  NUM_TRIALS  4   trials per run (>=1)
//  PULSE_W     2   cycles each A/B pulse is held high (>=1)
//  GAP_W       4   width of gap_cfg, cycles between the first and second pulse
//  TIMEOUT     8   max cycles to wait for O after the second pulse ends (>=1)
//  CNT_W       8   width of the pass/fail counters (saturating)
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      synchronous, active-high
//  start       in   1      1-cycle pulse, begins a run; ignored while busy
//  order_cfg   in   1      0: A first then B; 1: B first then A
//  gap_cfg     in   GAP_W  idle cycles between pulses; 0 = back-to-back
//  dut_reset   out  1      reset to the ABRO DUT
//  dut_A       out  1      A input to the DUT
//  dut_B       out  1      B input to the DUT
//  dut_O       in   1      O output from the DUT
//  busy        out  1      high from the cycle after start until done
//  done        out  1      1-cycle pulse at the end of a run
//  all_pass    out  1      valid with done and held until next start; 1 if fail_cnt==0
//  pass_cnt    out  CNT_W  trials passed this run
//  fail_cnt    out  CNT_W  trials failed this run
// BEHAVIOUR
//  Reset: FSM=IDLE, dut_reset=1, dut_A=dut_B=0, busy=done=all_pass=0, counters=0.
//  IDLE:     dut_reset held 1, DUT parked in reset. start -> RST_DUT, clear counters/trial idx.
//  RST_DUT:  dut_reset=1 for 2 cycles; latch order/gap for this trial; clear early flag.
//            -> FIRST with dut_reset=0.
//  FIRST:    first input high PULSE_W cycles.
//            -> GAP if gap>0, else straight to SECOND.
//  GAP:      A=B=0 for gap cycles. -> SECOND.
//  SECOND:   other input high PULSE_W cycles. -> WAIT_O.
//  WAIT_O:   A=B=0; wait up to TIMEOUT cycles for dut_O==1.
//            O seen: trial passes unless early flag set.
//            TIMEOUT cycles elapse without O: trial fails. -> SCORE.
//  Early O:  dut_O==1 in any FIRST or GAP cycle sets the early flag.
//            Sequence still runs to completion; the trial then fails.
//  SCORE:    1 cycle; bump pass_cnt or fail_cnt (saturate at 2^CNT_W-1).
//            Trial idx == NUM_TRIALS-1 -> DONE, else -> RST_DUT.
//  DONE:     done=1 one cycle, all_pass updated, busy=0. -> IDLE.
//  dut_A, dut_B and dut_reset are registered outputs: they change 1 cycle after the
//  state transition. dut_O is sampled the same cycle it arrives; no synchronizer.
//  start in the same cycle as reset: reset wins.
//  Reset mid-run: abort the run, no done pulse, counters cleared.
//  Trial length (no early O) = 2 + 2*PULSE_W + gap + wait + 1 cycles.
// CONFIGURATION
//  ABRO_DRV_LFSR_EN defined:
//   - 16-bit LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1 on reset, steps once per
//     RST_DUT entry.
//   - gap = lfsr[GAP_W-1:0], order = lfsr[GAP_W].
//   - order_cfg and gap_cfg are ignored.
//  Not defined: order_cfg/gap_cfg sampled at each RST_DUT entry; no LFSR logic built.
// TESTING
//  1. Good DUT, order_cfg=0, gap_cfg=3, start -> done after 4 trials,
//     pass_cnt=4, fail_cnt=0, all_pass=1.
//  2. order_cfg=1, gap_cfg=0 -> dut_B pulse ends and dut_A rises the next cycle
//     (no idle cycle between); all 4 trials pass.
//  3. DUT O stuck 0 -> each trial waits exactly TIMEOUT=8 cycles in WAIT_O;
//     fail_cnt=4, all_pass=0.
//  4. DUT asserts O after A alone -> early flag set; fail_cnt=4 even though O is high in WAIT_O.
//  5. reset asserted in GAP of trial 2 -> next cycle FSM=IDLE, dut_reset=1, counters=0, no done.
//  6. start pulsed while busy -> ignored; run ends at the same cycle as without it.

Source files
------------

// File: rtl/abro_stim_driver.sv
// ABRO stimulus driver and checker: runs reset/A/B trials into an ABRO block and scores O.
// Latency: trial = 2 + 2*PULSE_W + gap + wait + 1 cycles, done one cycle after the last SCORE.
// No backpressure: start is ignored while busy. Define ABRO_DRV_LFSR_EN for LFSR-chosen order/gap.
module abro_stim_driver #(
    parameter int NUM_TRIALS = 4,
    parameter int PULSE_W    = 2,
    parameter int GAP_W      = 4,
    parameter int TIMEOUT    = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             order_cfg,
    input  logic [GAP_W-1:0] gap_cfg,
    output logic             dut_reset,
    output logic             dut_A,
    output logic             dut_B,
    input  logic             dut_O,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam int M1 = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
    localparam int M2 = (M1 > (1 << GAP_W)) ? M1 : (1 << GAP_W);
    localparam int SW = $clog2(M2 + 1);
    localparam int TW = (NUM_TRIALS > 1) ? $clog2(NUM_TRIALS) : 1;
    localparam logic [SW-1:0] PULSE_LAST = SW'(PULSE_W - 1);
    localparam logic [SW-1:0] TO_LAST    = SW'(TIMEOUT - 1);
    localparam logic [SW-1:0] RST_LAST   = SW'(1);
    localparam logic [TW-1:0] TRIAL_LAST = TW'(NUM_TRIALS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_DUT, S_FIRST, S_GAP, S_SECOND, S_WAIT_O, S_SCORE, S_DONE
    } state_t;

    state_t           state, next_state;
    logic [SW-1:0]    step;
    logic [TW-1:0]    trial;
    logic             order_q;
    logic [GAP_W-1:0] gap_q;
    logic             early;
    logic             trial_ok;
    logic             enter_rst;
    logic             a_nxt, b_nxt, rst_nxt;
    logic             order_sel;
    logic [GAP_W-1:0] gap_sel;
    logic [SW-1:0]    gap_last;

    assign gap_last  = {{(SW-GAP_W){1'b0}}, gap_q} - SW'(1);
    assign enter_rst = (next_state == S_RST_DUT) && (state != S_RST_DUT);

`ifdef ABRO_DRV_LFSR_EN
    logic [15:0] lfsr, lfsr_step;
    wire         unused_cfg = ^{order_cfg, gap_cfg};

    // x^16 + x^14 + x^13 + x^11 + 1, advanced once per trial
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign order_sel = lfsr_step[GAP_W];
    assign gap_sel   = lfsr_step[GAP_W-1:0];

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 16'hACE1;
        else if (enter_rst)
            lfsr <= lfsr_step;
    end
`else
    assign order_sel = order_cfg;
    assign gap_sel   = gap_cfg;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        done       = 1'b0;
        rst_nxt    = 1'b0;
        a_nxt      = 1'b0;
        b_nxt      = 1'b0;
        case (state)
            S_IDLE: begin
                busy    = 1'b0;
                rst_nxt = 1'b1;
                if (start)
                    next_state = S_RST_DUT;
            end
            S_RST_DUT: begin
                rst_nxt = 1'b1;
                if (step == RST_LAST)
                    next_state = S_FIRST;
            end
            S_FIRST: begin
                a_nxt = !order_q;
                b_nxt = order_q;
                if (step == PULSE_LAST)
                    next_state = (gap_q != '0) ? S_GAP : S_SECOND;
            end
            S_GAP: begin
                if (step == gap_last)
                    next_state = S_SECOND;
            end
            S_SECOND: begin
                a_nxt = order_q;
                b_nxt = !order_q;
                if (step == PULSE_LAST)
                    next_state = S_WAIT_O;
            end
            S_WAIT_O: begin
                if (dut_O || (step == TO_LAST))
                    next_state = S_SCORE;
            end
            S_SCORE: begin
                next_state = (trial == TRIAL_LAST) ? S_DONE : S_RST_DUT;
            end
            S_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step      <= '0;
            trial     <= '0;
            order_q   <= 1'b0;
            gap_q     <= '0;
            early     <= 1'b0;
            trial_ok  <= 1'b0;
            dut_reset <= 1'b1;
            dut_A     <= 1'b0;
            dut_B     <= 1'b0;
            all_pass  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            dut_reset <= rst_nxt;
            dut_A     <= a_nxt;
            dut_B     <= b_nxt;
            step      <= (next_state != state) ? '0 : step + SW'(1);

            if (enter_rst) begin
                order_q <= order_sel;
                gap_q   <= gap_sel;
                early   <= 1'b0;
            end else if (((state == S_FIRST) || (state == S_GAP)) && dut_O) begin
                early <= 1'b1;
            end

            // Holds the verdict of the final WAIT_O cycle for SCORE
            if (state == S_WAIT_O)
                trial_ok <= dut_O && !early;

            if ((state == S_IDLE) && start) begin
                trial    <= '0;
                pass_cnt <= '0;
                fail_cnt <= '0;
                all_pass <= 1'b0;
            end

            if (state == S_SCORE) begin
                trial <= trial + TW'(1);
                if (trial_ok) begin
                    if (pass_cnt != {CNT_W{1'b1}})
                        pass_cnt <= pass_cnt + CNT_W'(1);
                end else if (fail_cnt != {CNT_W{1'b1}}) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                if (trial == TRIAL_LAST)
                    all_pass <= trial_ok && (fail_cnt == '0);
            end
        end
    end
endmodule

// File: tb/tb_abro_stim_driver.sv
// Bench for abro_stim_driver: an ABRO-like responder with good / stuck-at-0 / early-O modes,
// directed scenarios then randomized runs, all scored against counts derived from trial rules.
module tb_abro_stim_driver;
    localparam int NUM_TRIALS = 4;
    localparam int PULSE_W    = 2;
    localparam int GAP_W      = 4;
    localparam int TIMEOUT    = 8;
    localparam int CNT_W      = 8;
    localparam int M_GOOD  = 0;
    localparam int M_STUCK = 1;
    localparam int M_EARLY = 2;

    logic             clk = 1'b0;
    logic             reset, start, order_cfg;
    logic [GAP_W-1:0] gap_cfg;
    logic             dut_reset, dut_A, dut_B, dut_O;
    logic             busy, done, all_pass;
    logic [CNT_W-1:0] pass_cnt, fail_cnt;

    int checks = 0;
    int errors = 0;
    int dut_mode = M_GOOD;
    logic seen_a = 1'b0, seen_b = 1'b0, o_q = 1'b0;

    always #5 clk = ~clk;

    abro_stim_driver #(
        .NUM_TRIALS(NUM_TRIALS), .PULSE_W(PULSE_W), .GAP_W(GAP_W),
        .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .order_cfg(order_cfg),
        .gap_cfg(gap_cfg), .dut_reset(dut_reset), .dut_A(dut_A), .dut_B(dut_B),
        .dut_O(dut_O), .busy(busy), .done(done), .all_pass(all_pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    // Behavioural responder: O once both inputs seen (good) or once any input seen (early)
    always @(posedge clk) begin
        if (dut_reset) begin
            seen_a <= 1'b0;
            seen_b <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            seen_a <= seen_a | dut_A;
            seen_b <= seen_b | dut_B;
            if (dut_mode == M_EARLY)
                o_q <= o_q | dut_A | dut_B;
            else
                o_q <= o_q | ((seen_a | dut_A) & (seen_b | dut_B));
        end
    end
    assign dut_O = (dut_mode == M_STUCK) ? 1'b0 : o_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A/B seen while the DUT is out of reset: first input, gap idle cycles, second input, then idle
    task automatic pat_chk(input logic [1:0] r[$], input bit ord, input int gap);
        logic [1:0] first, second, e;
        bit ok;
        first  = ord ? 2'b01 : 2'b10;
        second = ord ? 2'b10 : 2'b01;
        ok = (r.size() >= 2 * PULSE_W + gap);
        foreach (r[i]) begin
            if (i < PULSE_W)                e = first;
            else if (i < PULSE_W + gap)     e = 2'b00;
            else if (i < 2 * PULSE_W + gap) e = second;
            else                            e = 2'b00;
            if (r[i] !== e) ok = 1'b0;
        end
        chk("pulse_pattern", {31'd0, ok}, 1);
    endtask

    task automatic do_run(input int mode, input bit ord, input int gap, input bit poke, input bit abort);
        logic [1:0] rec[$];
        int waitc, len, ncyc, trial, exp_fail, ndone;
        bit prev_rst, seen_done, aborted;
        waitc    = (mode == M_STUCK) ? TIMEOUT : 1;
        len      = NUM_TRIALS * (2 + 2 * PULSE_W + gap + waitc + 1);
        exp_fail = (mode == M_GOOD) ? 0 : NUM_TRIALS;
        dut_mode  = mode;
        order_cfg = ord;
        gap_cfg   = GAP_W'(gap);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ncyc = 1; trial = 0; prev_rst = 1'b1; seen_done = 1'b0; aborted = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!seen_done && !aborted && ncyc < len + 50) begin
            if (prev_rst && !dut_reset) begin
                trial++;
                rec.delete();
            end
            if (!prev_rst && dut_reset) pat_chk(rec, ord, gap);
            if (!dut_reset) rec.push_back({dut_A, dut_B});
            prev_rst = dut_reset;
            if (done)
                seen_done = 1'b1;
            else if (abort && trial == 2 && rec.size() == 2)
                aborted = 1'b1;
            else begin
                start = poke && (ncyc == 10);
                @(negedge clk);
                ncyc++;
            end
        end
        start = 1'b0;
        if (abort) begin
            chk("abort_point_reached", {31'd0, aborted}, 1);
            reset = 1'b1;
            @(negedge clk);
            chk("abort_busy", busy, 0);
            chk("abort_dut_reset", dut_reset, 1);
            chk("abort_pass_cnt", pass_cnt, 0);
            chk("abort_fail_cnt", fail_cnt, 0);
            chk("abort_done", done, 0);
            chk("abort_dut_A", dut_A, 0);
            reset = 1'b0;
            ndone = 0;
            repeat (60) begin
                @(negedge clk);
                if (done) ndone++;
            end
            chk("abort_no_done", ndone, 0);
        end else begin
            chk("done_seen", {31'd0, seen_done}, 1);
            chk("run_cycles", ncyc, len + 1);
            chk("trials_seen", trial, NUM_TRIALS);
            pat_chk(rec, ord, gap);
            chk("pass_cnt", pass_cnt, NUM_TRIALS - exp_fail);
            chk("fail_cnt", fail_cnt, exp_fail);
            chk("all_pass", all_pass, (exp_fail == 0) ? 1 : 0);
            @(negedge clk);
            chk("done_one_cycle", done, 0);
            chk("busy_idle", busy, 0);
            chk("all_pass_held", all_pass, (exp_fail == 0) ? 1 : 0);
        end
    endtask

    initial begin
        int md, gp;
        reset = 1'b1; start = 1'b1; order_cfg = 1'b0; gap_cfg = '0;
        repeat (3) @(negedge clk);
        chk("rst_dut_reset", dut_reset, 1);
        chk("rst_dut_A", dut_A, 0);
        chk("rst_dut_B", dut_B, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_all_pass", all_pass, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_with_reset_ignored", busy, 0);

        do_run(M_GOOD,  1'b0, 3, 1'b0, 1'b0);
        do_run(M_GOOD,  1'b1, 0, 1'b0, 1'b0);
        do_run(M_STUCK, 1'b0, 2, 1'b0, 1'b0);
        do_run(M_EARLY, 1'b0, 2, 1'b0, 1'b0);
        do_run(M_GOOD,  1'b0, 5, 1'b0, 1'b1);
        do_run(M_GOOD,  1'b1, 1, 1'b1, 1'b0);

        repeat (6) begin
            md = int'($urandom_range(2, 0));
            gp = int'($urandom_range(15, 0));
            // an early O is only distinguishable from a late one when a gap separates the pulses
            if (md == M_EARLY && gp == 0) gp = 1;
            do_run(md, 1'($urandom_range(1, 0)), gp, 1'($urandom_range(1, 0)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
